// File: rtl/comb_decimator_if.sv
// comb_decimator_if
//   Groups the sample stream of the comb decimator.
//   in_valid / in_data              : integrator samples into the decimator
//   out_valid / out_data / primed   : decimated, differentiated, scaled result
//   Modports:
//     slave  - the decimator (consumes in_*, drives out_* and primed)
//     master - the surrounding logic (drives in_*, observes out_* and primed)
interface comb_decimator_if #(
  parameter int WIDTH = 22
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             primed;

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output primed
  );

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  primed
  );
endinterface

// File: rtl/comb_decimator.sv
// comb_decimator
//   Decimates the integrator's Q2.20 stream by DECIM, applies a comb with
//   differential delay DIFF_DELAY (in decimated samples) and scales the
//   result by a rounding arithmetic right shift of SHIFT bits.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high reset
//     bus    - comb_decimator_if.slave: in_valid/in_data in,
//              out_valid/out_data/primed out
module comb_decimator #(
  parameter int WIDTH      = 22,
  parameter int DECIM      = 4,
  parameter int DIFF_DELAY = 1,
  parameter int SHIFT      = 2
) (
  input logic              clk,
  input logic              reset,
  comb_decimator_if.slave  bus
);

  localparam int PW        = (DECIM > 1) ? $clog2(DECIM) : 1;
  // Half an output LSB, added before the shift so the result rounds half up.
  // Evaluates to 0 when SHIFT is 0.
  localparam int ROUND_INT = (1 << SHIFT) >> 1;

  logic [PW-1:0]    phase_reg, phase_next;
  logic [1:0]       prime_reg, prime_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] delay_reg [DIFF_DELAY];

  logic                    capture;
  logic                    primed_now;
  logic [WIDTH-1:0]        diff;
  logic signed [WIDTH:0]   diff_ext;
  logic signed [WIDTH:0]   rounded;
  logic signed [WIDTH:0]   scaled;

  // A decimated sample is taken on the DECIM-th accepted input of each block.
  assign capture    = bus.in_valid && (phase_reg == PW'(DECIM - 1));
  assign primed_now = (prime_reg == 2'(DIFF_DELAY));

  // Modular subtraction: integrator wrap-around cancels in the comb.
  assign diff     = bus.in_data - delay_reg[DIFF_DELAY-1];
  // One guard bit so adding the rounding constant cannot overflow.
  assign diff_ext = $signed({diff[WIDTH-1], diff});
  assign rounded  = diff_ext + (WIDTH+1)'(ROUND_INT);
  assign scaled   = rounded >>> SHIFT;

  always_comb begin
    phase_next     = phase_reg;
    prime_next     = prime_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;

    if (bus.in_valid) begin
      if (phase_reg == PW'(DECIM - 1)) begin
        phase_next = '0;
      end else begin
        phase_next = phase_reg + PW'(1);
      end
    end

    if (capture) begin
      if (primed_now) begin
        out_valid_next = 1'b1;
        out_data_next  = WIDTH'(scaled);
      end else begin
        // Warm-up: this capture only fills the delay line.
        prime_next = prime_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg     <= '0;
      prime_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      phase_reg     <= phase_next;
      prime_reg     <= prime_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Comb delay line: tap 0 holds the newest captured sample, each further
  // tap the one captured before it.
  genvar gi;
  generate
    for (gi = 0; gi < DIFF_DELAY; gi++) begin : g_tap
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            delay_reg[gi] <= '0;
          end else if (capture) begin
            delay_reg[gi] <= bus.in_data;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) begin
            delay_reg[gi] <= '0;
          end else if (capture) begin
            delay_reg[gi] <= delay_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.primed    = primed_now;

endmodule
